platform_landing_scan: RTL
==========================

// Module: platform_landing_scan
// PURPOSE
// - Parametrised landing detector; next generation of the fixed platform constant set.
// - On a per-frame start pulse, scans a table of NUM_PLAT platforms, one slot per clock.
// - Reports whether the character's feet rest on a platform, which slot, and the snapped top-left Y.
// - Sits between the character movement FSM (jump/fall control) and the level geometry tables.
// PARAMETERS
// - NUM_PLAT  4   number of platform slots scanned (>=1)
// - HW        11  horizontal coordinate width
// - VW        11  vertical coordinate width
// - CHAR_W    64  character sprite width, px
// - CHAR_H    64  character sprite height, px
// - SNAP_TOL  8   max px the feet may sink below a surface and still count as landed
// - STEP_W    64  slope step width, px (power of 2; used only with SLOPE_EN)
// - STEP_DY   4   slope drop per step, px (used only with SLOPE_EN)
// PORTS
// - clk          in   1            system clock
// - rst          in   1            asynchronous, active-high reset
// - start        in   1            scan request pulse; accepted only when busy=0
// - char_x       in   HW           character top-left X; sampled on accepted start
// - char_y       in   VW           character top-left Y; sampled on accepted start
// - plat_en      in   NUM_PLAT     per-slot enable; 0 = slot never hits
// - plat_hstart  in   NUM_PLAT*HW  slot i left edge at [i*HW +: HW]
// - plat_hstop   in   NUM_PLAT*HW  slot i right edge, exclusive
// - plat_vtop    in   NUM_PLAT*VW  slot i surface Y at its hstart
// - plat_dir     in   NUM_PLAT     slot i slope direction, 1=down-right, 0=up-right (SLOPE_EN only)
// - busy         out  1            high in SCAN and DONE
// - done         out  1            one-cycle pulse; results valid from this cycle
// - on_ground    out  1            a landing surface was found
// - plat_idx     out  $clog2(NUM_PLAT) (min 1)  winning slot index
// - land_y       out  VW           snapped character top-left Y = surface_y - CHAR_H
// BEHAVIOUR
// - FSM IDLE -> SCAN -> DONE -> IDLE.
// - IDLE: start=1 latches char_x/char_y, clears best-hit regs, idx=0 -> SCAN.
// - SCAN: one slot per cycle; after slot NUM_PLAT-1 -> DONE.
// - DONE: one cycle; done=1; on_ground/plat_idx/land_y load; -> IDLE.
// - Latency: done asserts NUM_PLAT+1 cycles after the edge that sampled start.
// - start while busy=1 is ignored; no queueing. Geometry ports must be stable during SCAN.
// - Horizontal hit: char_x < hstop && char_x + CHAR_W > hstart (HW+1-bit sum, no wrap).
// - foot = char_y + CHAR_H (VW+1 bits).
// - Vertical hit: surface_y <= foot <= surface_y + SNAP_TOL (VW+1-bit compare).
// - Hit requires plat_en[i]=1 and both tests true.
// - Multiple hits: smallest surface_y wins; tie -> lowest index (strict < on update).
// - No hit: on_ground=0, plat_idx=0, land_y=0 in DONE.
// - Results held from DONE until the next DONE.
// - Reset (any state, async): state=IDLE; busy, done, on_ground, plat_idx, land_y = 0.
// - Reset mid-scan aborts with no done pulse.
// - All outputs registered.
// CONFIGURATION
// - Macro PLATFORM_SLOPE_EN.
// - Defined: surface_y = vtop +/- ((cx - hstart) >> log2(STEP_W)) * STEP_DY.
//   - cx = char_x + CHAR_W/2, clamped to [hstart, hstop-1].
//   - '+' when plat_dir[i]=1, '-' when 0; result saturates at 0 and 2**VW-1.
// - Undefined: surface_y = vtop, plat_dir ignored (port kept), no multiplier synthesised.
// TESTING
// - Table {vtop,hstart,hstop}: s0={736,0,512}, s1={239,0,640}, s2={128,320,576}, s3={600,700,1024}; en=4'b1111.
// - x=100, y=672, start -> done 5 cycles later; on_ground=1, idx=0, land_y=672.
// - x=100, y=660 (foot 724 < 736) -> on_ground=0, idx=0, land_y=0.
// - s3 := s0 copy; x=100, y=676 -> tie; idx=0, land_y=672.
// - Second start pulse 2 cycles into SCAN -> ignored; exactly one done, same latency.
// - rst at SCAN cycle 2 -> all outputs 0 immediately; no done.
// - Restart after reset -> normal result.
// - PLATFORM_SLOPE_EN, s0 dir=1, x=100, y=680 -> cx=132, surface 744; on_ground=1, land_y=680.

Source files
------------

// File: rtl/platform_landing_scan.sv
// rtl/platform_landing_scan.sv - per-frame platform landing scan, one slot per clock
// Optional sloped surfaces under macro PLATFORM_SLOPE_EN.
module platform_landing_scan #(
  parameter int NUM_PLAT = 4,
  parameter int HW       = 11,
  parameter int VW       = 11,
  parameter int CHAR_W   = 64,
  parameter int CHAR_H   = 64,
  parameter int SNAP_TOL = 8,
  parameter int STEP_W   = 64,
  parameter int STEP_DY  = 4,
  localparam int IW      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [HW-1:0]          char_x,
  input  logic [VW-1:0]          char_y,
  input  logic [NUM_PLAT-1:0]    plat_en,
  input  logic [NUM_PLAT*HW-1:0] plat_hstart,
  input  logic [NUM_PLAT*HW-1:0] plat_hstop,
  input  logic [NUM_PLAT*VW-1:0] plat_vtop,
  input  logic [NUM_PLAT-1:0]    plat_dir,
  output logic                   busy,
  output logic                   done,
  output logic                   on_ground,
  output logic [IW-1:0]          plat_idx,
  output logic [VW-1:0]          land_y
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t        state;
  logic [HW-1:0] cx_r;
  logic [VW-1:0] cy_r;
  logic [IW-1:0] idx;
  logic          found;
  logic [VW-1:0] best_y;
  logic [IW-1:0] best_idx;

  logic [HW-1:0] hs, he;
  logic [VW-1:0] vt, surf;
  logic [VW:0]   foot;
  logic          hhit, vhit, hit;

  assign hs   = plat_hstart[idx*HW +: HW];
  assign he   = plat_hstop[idx*HW +: HW];
  assign vt   = plat_vtop[idx*VW +: VW];
  assign foot = {1'b0, cy_r} + (VW+1)'(CHAR_H);
  assign hhit = ({1'b0, cx_r} < {1'b0, he}) &&
                (({1'b0, cx_r} + (HW+1)'(CHAR_W)) > {1'b0, hs});
  assign vhit = (foot >= {1'b0, surf}) &&
                (foot <= ({1'b0, surf} + (VW+1)'(SNAP_TOL)));
  assign hit  = plat_en[idx] && hhit && vhit;

`ifdef PLATFORM_SLOPE_EN
  localparam int SH = $clog2(STEP_W);
  localparam int DW = HW + VW + 8;

  logic [HW:0]   cx_c, cx_cl, dx;
  logic [DW-1:0] delta, up_sum;

  // Surface height is evaluated under the sprite's horizontal centre, clamped onto the slot.
  always_comb begin
    cx_c = {1'b0, cx_r} + (HW+1)'(CHAR_W / 2);
    if (cx_c < {1'b0, hs})
      cx_cl = {1'b0, hs};
    else if (cx_c >= {1'b0, he})
      cx_cl = {1'b0, he} - (HW+1)'(1);
    else
      cx_cl = cx_c;
    dx     = (cx_cl - {1'b0, hs}) >> SH;
    delta  = DW'(dx) * DW'(STEP_DY);
    up_sum = DW'(vt) + delta;
    surf   = vt;
    if (plat_dir[idx])
      surf = (up_sum > DW'((2 ** VW) - 1)) ? '1 : up_sum[VW-1:0];
    else
      surf = (delta > DW'(vt)) ? '0 : (vt - delta[VW-1:0]);
  end
`else
  logic unused_cfg;
  assign surf       = vt;
  assign unused_cfg = ^{plat_dir, STEP_W[0], STEP_DY[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      on_ground <= 1'b0;
      plat_idx  <= '0;
      land_y    <= '0;
      cx_r      <= '0;
      cy_r      <= '0;
      idx       <= '0;
      found     <= 1'b0;
      best_y    <= '0;
      best_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cx_r     <= char_x;
            cy_r     <= char_y;
            found    <= 1'b0;
            best_y   <= '0;
            best_idx <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Strict less-than keeps the lowest index on equal heights.
          if (hit && (!found || (surf < best_y))) begin
            found    <= 1'b1;
            best_y   <= surf;
            best_idx <= idx;
          end
          if (idx == IW'(NUM_PLAT - 1))
            state <= S_DONE;
          else
            idx <= idx + IW'(1);
        end
        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          on_ground <= found;
          plat_idx  <= found ? best_idx : '0;
          land_y    <= found ? (best_y - VW'(CHAR_H)) : '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
